lut_gpio_writer: RTL
====================

LUT_GPIO_WRITER -- requirements
Module: lut_gpio_writer

Interface
REQ-001 Parameter addr_reg, default 0, GPIO register address of the LUT address register.
REQ-002 Parameter data_reg, default 1, GPIO register address of the LUT data register.
REQ-003 Parameter strobe_cycles, default 4, clk cycles w_clk is held high and then held low per GPIO write (legal 1..255).
REQ-004 Port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 Port rst  input  1  asynchronous, active-low reset.
REQ-006 Port start  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-007 Port start_addr  input  16  first LUT address; sampled with start.
REQ-008 Port word_count  input  16  number of 16-bit entries to write; sampled with start.
REQ-009 Port s_data  input  16  LUT entry to write.
REQ-010 Port s_valid  input  1  s_data valid.
REQ-011 Port s_ready  output  1  block accepts s_data this cycle.
REQ-012 Port gpio_out  output  32  GPIO bus: [7:0] data byte, [15:8] register address, [16] w_clk, [31:17] zero.
REQ-013 Port busy  output  1  high from the cycle after an accepted start until done.
REQ-014 Port done  output  1  one-cycle pulse when the load completes.

Function
REQ-015 A GPIO write SHALL be three phases: SETUP (1 cycle, fields driven, w_clk=0), HIGH (strobe_cycles, w_clk=1), LOW (strobe_cycles, w_clk=0); fields SHALL stay constant across all three phases; total 1+2*strobe_cycles cycles.
REQ-016 Top FSM states SHALL be IDLE, ADDR_HI, ADDR_LO, WAIT_WORD, DATA_HI, DATA_LO, FINISH.
REQ-017 IDLE: start=1 SHALL latch start_addr and word_count, and go to ADDR_HI; start in any other state SHALL be ignored.
REQ-018 ADDR_HI SHALL perform one write {addr_reg, start_addr[15:8]}; ADDR_LO SHALL perform one write {addr_reg, start_addr[7:0]}.
REQ-019 After ADDR_LO: remaining count zero -> FINISH, else -> WAIT_WORD.
REQ-020 WAIT_WORD SHALL drive s_ready=1; s_ready SHALL be 0 in all other states; s_valid&s_ready SHALL latch s_data, decrement the remaining count, and go to DATA_HI.
REQ-021 DATA_HI SHALL write {data_reg, word[15:8]}; DATA_LO SHALL write {data_reg, word[7:0]}; then remaining zero -> FINISH, else -> WAIT_WORD.
REQ-022 FINISH SHALL pulse done=1 for exactly one cycle, drop busy in the same cycle, and return to IDLE; start is accepted again the following cycle.
REQ-023 The block SHALL NOT advance the LUT address itself; the addressed LUT auto-increments on data writes.
REQ-024 While s_valid is low in WAIT_WORD the block SHALL hold gpio_out with w_clk=0 indefinitely (no timeout).
REQ-025 In IDLE gpio_out SHALL be 0.
REQ-026 word_count=0 SHALL produce exactly two address writes, zero data writes, then done.

Reset
REQ-027 rst low SHALL immediately force state IDLE, gpio_out=0, s_ready=0, busy=0, done=0, and clear latched address, count, word and phase counter, including mid-write; the interrupted transfer is abandoned.

Structure
REQ-028 GPIO field positions (data LSB/width, address LSB/width, w_clk bit) SHALL live in a shared package gpio_bus_pkg, also used by GPIO receivers.
REQ-029 The three-phase strobe timing SHALL be one sub-module gpio_write_phy (inputs req, addr, data; outputs gpio_out, ack pulsed at end of LOW).

Verification
REQ-030 strobe_cycles=4, start_addr=0x1234, word_count=1, s_data=0xABCD valid -> writes {0,0x12},{0,0x34},{1,0xAB},{1,0xCD}, each 9 cycles, w_clk high exactly 4 cycles; done pulses once.
REQ-031 word_count=0, start_addr=0x00FF -> only {0,0x00},{0,0xFF}; done 1 cycle after second write; s_ready never high.
REQ-032 word_count=3, s_valid held low 20 cycles at second WAIT_WORD -> gpio_out constant with w_clk=0 for 20 cycles; then 0x0001,0x8000 written correctly; total 8 GPIO writes.
REQ-033 start asserted while busy with start_addr=0xFFFF -> ignored; the original load completes unchanged.
REQ-034 rst pulsed low during HIGH phase of a data write -> same-cycle gpio_out=0, busy=0; a new start afterwards runs normally.
REQ-035 Back-to-back loads: start in the cycle after done -> accepted; address writes begin with no extra idle gap.

Source files
------------

// File: rtl/gpio_bus_pkg.sv
// Field layout of the 32-bit GPIO register-write bus, shared by the writer and
// by any GPIO receiver that decodes it.
package gpio_bus_pkg;

  localparam int GPIO_W        = 32;
  localparam int GPIO_DATA_LSB = 0;
  localparam int GPIO_DATA_W   = 8;
  localparam int GPIO_ADDR_LSB = 8;
  localparam int GPIO_ADDR_W   = 8;
  localparam int GPIO_WCLK_BIT = 16;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_HIGH,
    PH_LOW
  } wr_phase_e;

  function automatic logic [GPIO_W-1:0] gpio_pack(
    input logic [GPIO_ADDR_W-1:0] addr,
    input logic [GPIO_DATA_W-1:0] data,
    input logic                   w_clk
  );
    logic [GPIO_W-1:0] v;
    v = '0;
    v[GPIO_DATA_LSB +: GPIO_DATA_W] = data;
    v[GPIO_ADDR_LSB +: GPIO_ADDR_W] = addr;
    v[GPIO_WCLK_BIT] = w_clk;
    return v;
  endfunction

endpackage

// File: rtl/gpio_write_phy.sv
// One GPIO register write: SETUP (1 cycle), w_clk HIGH and LOW (strobe_cycles each).
// A req seen on the final LOW cycle chains the next write with no idle gap.
module gpio_write_phy
  import gpio_bus_pkg::*;
#(
  parameter int unsigned strobe_cycles = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [7:0]  addr,
  input  logic [7:0]  data,
  output logic [31:0] gpio_out,
  output logic        ack
);

  localparam logic [7:0] STROBE_LAST = 8'(strobe_cycles - 1);

  wr_phase_e   phase_q, phase_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [31:0] gpio_q, gpio_d;

  assign ack      = (phase_q == PH_LOW) && (cnt_q == 8'd0);
  assign gpio_out = gpio_q;

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (phase_q)
      PH_IDLE: begin
        if (req) begin
          phase_d = PH_SETUP;
          addr_d  = addr;
          data_d  = data;
        end
      end
      PH_SETUP: begin
        phase_d = PH_HIGH;
        cnt_d   = STROBE_LAST;
      end
      PH_HIGH: begin
        if (cnt_q == 8'd0) begin
          phase_d = PH_LOW;
          cnt_d   = STROBE_LAST;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      PH_LOW: begin
        if (cnt_q == 8'd0) begin
          if (req) begin
            phase_d = PH_SETUP;
            addr_d  = addr;
            data_d  = data;
          end else begin
            phase_d = PH_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: phase_d = PH_IDLE;
    endcase
    gpio_d = (phase_d == PH_IDLE) ? '0 : gpio_pack(addr_d, data_d, phase_d == PH_HIGH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      gpio_q  <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      gpio_q  <= gpio_d;
    end
  end

endmodule

// File: rtl/lut_gpio_writer.sv
// Loads a LUT over the GPIO register bus: two address-byte writes, then two
// data-byte writes per streamed 16-bit entry (the LUT auto-increments).
//
// state      | meaning
// IDLE       | waiting for start, gpio_out parked at zero
// ADDR_HI    | writing start_addr[15:8] to the address register
// ADDR_LO    | writing start_addr[7:0] to the address register
// WAIT_WORD  | s_ready high, waiting for the next entry
// DATA_HI    | writing entry[15:8] to the data register
// DATA_LO    | writing entry[7:0] to the data register
// FINISH     | one-cycle done pulse, busy already low
module lut_gpio_writer
  import gpio_bus_pkg::*;
#(
  parameter logic [7:0]  addr_reg      = 8'd0,
  parameter logic [7:0]  data_reg      = 8'd1,
  parameter int unsigned strobe_cycles = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] start_addr,
  input  logic [15:0] word_count,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] gpio_out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_WAIT_WORD,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_FINISH
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] lut_addr_q, lut_addr_d;
  logic [15:0] remain_q, remain_d;
  logic [15:0] word_q, word_d;
  logic        s_ready_q, s_ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        phy_req;
  logic [7:0]  phy_addr;
  logic [7:0]  phy_data;
  logic        phy_ack;

  // Write requests are raised on the transition into a write state so the
  // phy's SETUP cycle lines up with the first cycle of that state.
  always_comb begin
    state_d    = state_q;
    lut_addr_d = lut_addr_q;
    remain_d   = remain_q;
    word_d     = word_q;
    phy_req    = 1'b0;
    phy_addr   = '0;
    phy_data   = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_ADDR_HI;
          lut_addr_d = start_addr;
          remain_d   = word_count;
          phy_req    = 1'b1;
          phy_addr   = addr_reg;
          phy_data   = start_addr[15:8];
        end
      end
      ST_ADDR_HI: begin
        if (phy_ack) begin
          state_d  = ST_ADDR_LO;
          phy_req  = 1'b1;
          phy_addr = addr_reg;
          phy_data = lut_addr_q[7:0];
        end
      end
      ST_ADDR_LO: begin
        if (phy_ack) state_d = (remain_q == 16'd0) ? ST_FINISH : ST_WAIT_WORD;
      end
      ST_WAIT_WORD: begin
        if (s_valid && s_ready_q) begin
          state_d  = ST_DATA_HI;
          word_d   = s_data;
          remain_d = remain_q - 16'd1;
          phy_req  = 1'b1;
          phy_addr = data_reg;
          phy_data = s_data[15:8];
        end
      end
      ST_DATA_HI: begin
        if (phy_ack) begin
          state_d  = ST_DATA_LO;
          phy_req  = 1'b1;
          phy_addr = data_reg;
          phy_data = word_q[7:0];
        end
      end
      ST_DATA_LO: begin
        if (phy_ack) state_d = (remain_q == 16'd0) ? ST_FINISH : ST_WAIT_WORD;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    s_ready_d = (state_d == ST_WAIT_WORD);
    busy_d    = (state_d != ST_IDLE) && (state_d != ST_FINISH);
    done_d    = (state_d == ST_FINISH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      lut_addr_q <= '0;
      remain_q   <= '0;
      word_q     <= '0;
      s_ready_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lut_addr_q <= lut_addr_d;
      remain_q   <= remain_d;
      word_q     <= word_d;
      s_ready_q  <= s_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  gpio_write_phy #(
    .strobe_cycles(strobe_cycles)
  ) u_phy (
    .clk     (clk),
    .rst_n   (rst),
    .req     (phy_req),
    .addr    (phy_addr),
    .data    (phy_data),
    .gpio_out(gpio_out),
    .ack     (phy_ack)
  );

  assign s_ready = s_ready_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
